// File: rtl/adc_pkt_engine.sv
// rtl/adc_pkt_engine.sv - ADC sample capture into frame RAM and byte-wide UDP payload streamer
module adc_pkt_engine #(
  parameter int N_CH     = 6,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 85
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [15:0]              burst_len,
  input  logic                     sample_valid,
  input  logic [N_CH*SAMPLE_W-1:0] sample_data,
  output logic                     hdr_valid,
  input  logic                     hdr_ready,
  output logic [15:0]              udp_length,
  output logic [7:0]               m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     busy,
  output logic [15:0]              seq_num,
  output logic [15:0]              drop_count
);
  localparam int WORD_W = N_CH * SAMPLE_W;
  localparam int BPS    = SAMPLE_W / 8;
  localparam int BPW    = N_CH * BPS;
  localparam int TOTAL  = 4 + DEPTH * BPW;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(TOTAL);
  localparam int BW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [15:0] UDP_LEN = 16'(8 + TOTAL);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HDR, S_PAYLOAD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       burst_q, burst_d, pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       seq_q, seq_d, drop_q, drop_d;
  logic              ovf_q, ovf_d, hdr_ovf_q, hdr_ovf_d, stop_pend_q, stop_pend_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, widx_q, widx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bsel_q, bsel_d;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] word_q;
  logic [7:0]        word_bytes [BPW];
  logic              hs, xfer, last_byte, eop, drop, burst_done, pkt_final, arm, rd_en;
  logic [AW-1:0]     rd_addr;
  logic [15:0]       burst_eff;

  assign arm        = (state_q == S_IDLE) && start && !stop;
  assign hs         = (state_q == S_HDR) && hdr_ready;
  assign xfer       = (state_q == S_PAYLOAD) && m_tready;
  assign last_byte  = (cnt_q == CW'(TOTAL - 1));
  assign eop        = xfer && last_byte;
  assign drop       = sample_valid && ((state_q == S_HDR) || (state_q == S_PAYLOAD));
  assign burst_eff  = (burst_q == 16'd0) ? 16'd1 : burst_q;
  assign burst_done = ({1'b0, pkt_cnt_q} + 17'd1) >= {1'b0, burst_eff};
  assign pkt_final  = stop_pend_q || stop || (mode_q == 2'd0) || (mode_q == 2'd3) ||
                      ((mode_q == 2'd1) && burst_done);
  // Next word is fetched while the last byte of the current one leaves, so bytes never bubble.
  assign rd_en      = hs || (xfer && (cnt_q >= CW'(4)) && (bsel_q == BW'(BPW - 1)) && !last_byte);
  assign rd_addr    = hs ? '0 : widx_q + 1'b1;
  assign udp_length = UDP_LEN;
  assign seq_num    = seq_q;
  assign drop_count = drop_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm) state_d = S_FILL;
      S_FILL:    if (stop) state_d = S_IDLE;
                 else if (sample_valid && (wr_ptr_q == AW'(DEPTH - 1))) state_d = S_HDR;
      S_HDR:     if (hdr_ready) state_d = S_PAYLOAD;
      S_PAYLOAD: if (eop) state_d = pkt_final ? S_IDLE : S_FILL;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: config latch, fill pointer, byte counters, sequence and drop accounting
  always_comb begin
    mode_d      = mode_q;
    burst_d     = burst_q;
    pkt_cnt_d   = pkt_cnt_q;
    seq_d       = seq_q;
    drop_d      = drop_q;
    ovf_d       = ovf_q;
    hdr_ovf_d   = hdr_ovf_q;
    stop_pend_d = stop_pend_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    bsel_d      = bsel_q;
    widx_d      = widx_q;
    if (arm) begin
      mode_d      = mode;
      burst_d     = burst_len;
      pkt_cnt_d   = '0;
      stop_pend_d = 1'b0;
      wr_ptr_d    = '0;
    end
    if (state_q == S_FILL) begin
      if (stop) wr_ptr_d = '0;
      else if (sample_valid) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (((state_q == S_HDR) || (state_q == S_PAYLOAD)) && stop) stop_pend_d = 1'b1;
    if (hs) begin
      cnt_d  = '0;
      bsel_d = '0;
      widx_d = '0;
    end
    if (xfer) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CW'(4)) begin
        if (bsel_q == BW'(BPW - 1)) begin
          bsel_d = '0;
          widx_d = widx_q + 1'b1;
        end else begin
          bsel_d = bsel_q + 1'b1;
        end
      end
    end
    if (drop) begin
      drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
      ovf_d  = 1'b1;
    end
    // Overflow seen during this packet is reported in the next packet's header.
    if (eop) begin
      seq_d       = seq_q + 16'd1;
      pkt_cnt_d   = pkt_cnt_q + 16'd1;
      hdr_ovf_d   = ovf_q | drop;
      ovf_d       = 1'b0;
      stop_pend_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 2'd0;
      burst_q     <= 16'd0;
      pkt_cnt_q   <= 16'd0;
      seq_q       <= 16'd0;
      drop_q      <= 16'd0;
      ovf_q       <= 1'b0;
      hdr_ovf_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      bsel_q      <= '0;
      widx_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      burst_q     <= burst_d;
      pkt_cnt_q   <= pkt_cnt_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      hdr_ovf_q   <= hdr_ovf_d;
      stop_pend_q <= stop_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      bsel_q      <= bsel_d;
      widx_q      <= widx_d;
    end
  end

  // Frame RAM: write port during fill, registered read port feeding the serialiser
  always_ff @(posedge clk) begin
    if ((state_q == S_FILL) && sample_valid && !stop) mem[wr_ptr_q] <= sample_data;
    if (rd_en) word_q <= mem[rd_addr];
  end

  // Reorder the word into transmit byte order: channel 0 first, each sample MSB byte first
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      for (int j = 0; j < BPS; j++) begin
        word_bytes[c*BPS + j] = word_q[c*SAMPLE_W + SAMPLE_W - 8*(j+1) +: 8];
      end
    end
  end

  // Outputs decoded from state and byte position
  always_comb begin
    hdr_valid = (state_q == S_HDR);
    m_tvalid  = (state_q == S_PAYLOAD);
    busy      = (state_q != S_IDLE);
    m_tlast   = m_tvalid && last_byte;
    m_tdata   = 8'h00;
    if (m_tvalid) begin
      if (cnt_q == CW'(0))      m_tdata = seq_q[15:8];
      else if (cnt_q == CW'(1)) m_tdata = seq_q[7:0];
      else if (cnt_q == CW'(2)) m_tdata = 8'(N_CH);
      else if (cnt_q == CW'(3)) m_tdata = {7'b0, hdr_ovf_q};
      else                      m_tdata = word_bytes[bsel_q];
    end
  end
endmodule

// File: tb/tb_adc_pkt_engine.sv
// tb/tb_adc_pkt_engine.sv - self-checking bench for adc_pkt_engine
module tb_adc_pkt_engine;
  localparam int N_CH = 2, SAMPLE_W = 16, DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] burst_len = 16'd0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = 32'd0;
  logic        hdr_ready = 1'b1, m_tready = 1'b1;
  logic        hdr_valid, m_tvalid, m_tlast, busy;
  logic [7:0]  m_tdata;
  logic [15:0] udp_length, seq_num, drop_count;

  adc_pkt_engine #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len),
    .sample_valid(sample_valid), .sample_data(sample_data), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .udp_length(udp_length), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .seq_num(seq_num), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_pass = 0, hdr_hs = 0;
  logic [7:0]  exp_data [$];
  bit          exp_last [$];
  logic [7:0]  cap [$];
  bit          cap_en = 1'b0, tready_rand = 1'b0;
  logic [15:0] m_seq = 16'd0;
  bit          m_carry = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cword(input int k);
    return {16'(k) ^ 16'hA5A5, 16'(k)};
  endfunction

  // Expected packet: header from model sequence/overflow, then each sample MSB byte first
  task automatic push_pkt(input logic [31:0] w [4], input bit drops);
    logic [7:0] b [$];
    logic [15:0] s;
    b = '{m_seq[15:8], m_seq[7:0], 8'(N_CH), {7'b0, m_carry}};
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        s = w[i][c*SAMPLE_W +: SAMPLE_W];
        b.push_back(s[15:8]);
        b.push_back(s[7:0]);
      end
    end
    for (int k = 0; k < b.size(); k++) begin
      exp_data.push_back(b[k]);
      exp_last.push_back(k == b.size() - 1);
    end
    m_seq   = m_seq + 16'd1;
    m_carry = drops;
  endtask

  task automatic run_single(input logic [31:0] w [4]);
    mode  = 2'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sample_valid = 1'b1;
      sample_data  = w[i];
      cyc();
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while ((busy !== 1'b0 || exp_data.size() != 0) && n < max) begin
      cyc();
      n++;
    end
    chk({name, "_done"}, {31'd0, (busy === 1'b0) && (exp_data.size() == 0)}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    cyc();
    cyc();
    exp_data.delete();
    exp_last.delete();
    m_seq   = 16'd0;
    m_carry = 1'b0;
    rst_n   = 1'b1;
    cyc();
  endtask

  always begin
    @(posedge clk);
    #1 m_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every transferred byte against the model, plus handshake rules
  bit         prev_stall = 1'b0, prev_hs = 1'b0, hs_wait = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  int         lat = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0; prev_hs = 1'b0; hs_wait = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("stall_tdata", {24'd0, m_tdata}, {24'd0, prev_data});
        chk("stall_tlast", {31'd0, m_tlast}, {31'd0, prev_last});
      end
      if (prev_hs) chk("hdr_valid_drops", {31'd0, hdr_valid}, 32'd0);
      if (hs_wait) begin
        lat++;
        if (m_tvalid || lat > 2) begin
          chk("first_byte_latency", {31'd0, m_tvalid && lat <= 2}, 32'd1);
          hs_wait = 1'b0;
        end
      end
      if (hdr_valid && hdr_ready) begin
        hdr_hs++;
        hs_wait = 1'b1;
        lat = 0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", m_tdata);
        end else begin
          chk("payload_byte", {24'd0, m_tdata}, {24'd0, exp_data.pop_front()});
          chk("payload_tlast", {31'd0, m_tlast}, {31'd0, exp_last.pop_front()});
        end
        if (cap_en) cap.push_back(m_tdata);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_hs    = hdr_valid && hdr_ready;
    end
  end

  initial begin
    logic [31:0] w [4];
    logic [7:0]  lit [20];
    int          hs0, n;

    cyc();
    cyc();
    chk("rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_tdata", {24'd0, m_tdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_seq", {16'd0, seq_num}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("udp_length", {16'd0, udp_length}, 32'h1C);
    rst_n = 1'b1;
    cyc();

    // single packet, literal byte stream
    w   = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    lit = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h22, 8'h22, 8'h11, 8'h11, 8'h44, 8'h44,
            8'h33, 8'h33, 8'h66, 8'h66, 8'h55, 8'h55, 8'h88, 8'h88, 8'h77, 8'h77};
    hs0 = hdr_hs;
    push_pkt(w, 1'b0);
    cap_en = 1'b1;
    run_single(w);
    wait_done("single", 100);
    cap_en = 1'b0;
    chk("single_nbytes", cap.size(), 32'd20);
    for (int i = 0; i < 20 && i < cap.size(); i++) chk("single_literal_byte", {24'd0, cap[i]}, {24'd0, lit[i]});
    chk("single_hdr_once", hdr_hs - hs0, 32'd1);
    chk("single_seq", {16'd0, seq_num}, 32'd1);

    // random backpressure on the payload
    for (int i = 0; i < DEPTH; i++) w[i] = $urandom;
    push_pkt(w, 1'b0);
    tready_rand = 1'b1;
    run_single(w);
    wait_done("backpressure", 400);
    tready_rand = 1'b0;
    chk("backpressure_seq", {16'd0, seq_num}, 32'd2);

    // burst of 3 with a sample every cycle: each packet drops HDR(1)+PAYLOAD(20) samples
    do_reset();
    hs0 = hdr_hs;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < DEPTH; i++) w[i] = cword(1 + 25*p + i);
      push_pkt(w, 1'b1);
    end
    mode = 2'd1;
    burst_len = 16'd3;
    for (int k = 0; k < 80; k++) begin
      start = (k == 0); sample_valid = 1'b1; sample_data = cword(k);
      cyc();
    end
    start = 1'b0; sample_valid = 1'b0;
    wait_done("burst", 100);
    chk("burst_drops", {16'd0, drop_count}, 32'd63);
    chk("burst_seq", {16'd0, seq_num}, 32'd3);
    chk("burst_hdr_count", hdr_hs - hs0, 32'd3);

    // continuous, stop during payload of the 5th packet
    hs0 = hdr_hs;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < DEPTH; i++) w[i] = cword(1 + 25*p + i);
      push_pkt(w, 1'b1);
    end
    mode = 2'd2;
    for (int k = 0; k < 130; k++) begin
      start = (k == 0); stop = (k == 110); sample_valid = 1'b1; sample_data = cword(k);
      cyc();
    end
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    wait_done("cont_stop", 100);
    chk("cont_hdr_count", hdr_hs - hs0, 32'd5);
    chk("cont_seq", {16'd0, seq_num}, 32'd8);
    chk("cont_drops", {16'd0, drop_count}, 32'd168);

    // stop during fill discards the partial frame
    hs0 = hdr_hs;
    mode = 2'd0; start = 1'b1;
    cyc();
    start = 1'b0; sample_valid = 1'b1; sample_data = cword(1000);
    cyc();
    sample_data = cword(1001);
    cyc();
    sample_valid = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("fillstop_busy", {31'd0, busy}, 32'd0);
    cyc();
    chk("fillstop_seq", {16'd0, seq_num}, 32'd8);
    chk("fillstop_no_hdr", hdr_hs - hs0, 32'd0);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_same_idle", {31'd0, busy}, 32'd0);
    cyc();
    for (int i = 0; i < DEPTH; i++) w[i] = cword(2000 + i);
    push_pkt(w, 1'b0);
    run_single(w);
    wait_done("refill", 100);
    chk("refill_seq", {16'd0, seq_num}, 32'd9);

    // sequence number wrap
    force dut.seq_q = 16'hFFFF;
    cyc();
    release dut.seq_q;
    cyc();
    chk("wrap_preload", {16'd0, seq_num}, 32'hFFFF);
    m_seq = 16'hFFFF;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) w[i] = cword(3000 + 4*r + i);
      push_pkt(w, 1'b0);
      run_single(w);
      wait_done("wrap", 100);
    end
    chk("wrap_seq", {16'd0, seq_num}, 32'd1);

    // drop counter saturation while the header is held off
    hdr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) w[i] = cword(4000 + i);
    push_pkt(w, 1'b1);
    run_single(w);
    sample_valid = 1'b1;
    for (int k = 0; k < 65500; k++) begin
      sample_data = cword(k);
      cyc();
    end
    chk("sat_hdr_valid_held", {31'd0, hdr_valid}, 32'd1);
    chk("sat_drop_count", {16'd0, drop_count}, 32'hFFFF);
    sample_valid = 1'b0;
    hdr_ready = 1'b1;
    wait_done("sat", 100);
    chk("sat_drop_after", {16'd0, drop_count}, 32'hFFFF);

    // reset in the middle of a payload
    for (int i = 0; i < DEPTH; i++) w[i] = cword(5000 + i);
    push_pkt(w, 1'b0);
    run_single(w);
    n = 0;
    while (exp_data.size() > 14 && n < 50) begin
      cyc();
      n++;
    end
    chk("midrst_in_payload", {31'd0, m_tvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_seq", {16'd0, seq_num}, 32'd0);
    chk("midrst_drop", {16'd0, drop_count}, 32'd0);
    exp_data.delete();
    exp_last.delete();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
